// File: rtl/cvxif_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_result_queue
// Description : Result FIFO between the vector coprocessor and the CV-X-IF
//               result input of the core. Ready depends on registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_result_queue #(
  parameter int ID_W   = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ID_W-1:0]            in_id_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic [4:0]                 in_rd_i,
  input  logic                       in_we_i,
  input  logic                       in_exc_i,
  input  logic [5:0]                 in_exccode_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ID_W-1:0]            out_id_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_we_o,
  output logic                       out_exc_o,
  output logic [5:0]                 out_exccode_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ID_W + DATA_W + 5 + 1 + 1 + 6;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_head;

  assign in_ready_o  = (r_count != C_FULL);
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;
  assign count_o     = r_count;

  assign w_in_entry = {in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i, in_exccode_i};
  // Head fields are zeroed while empty so stale storage never leaks out.
  assign w_head     = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign {out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o} = w_head;

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Explicit wrap at DEPTH-1 keeps non-power-of-two depths correct.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (r_count != C_FULL));
  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(w_head));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= C_FULL);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cvxif_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cvxif_result_queue
// Description : Directed self-checking bench for cvxif_result_queue (DEPTH 4 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_result_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        flush = 1'b0, in_valid = 1'b0, in_ready, in_we = 1'b0, in_exc = 1'b0;
  logic [2:0]  in_id = '0, out_id;
  logic [31:0] in_data = '0, out_data;
  logic [4:0]  in_rd = '0, out_rd;
  logic [5:0]  in_exccode = '0, out_exccode;
  logic        out_valid, out_ready = 1'b0, out_we, out_exc;
  logic [2:0]  count;

  logic        flush3 = 1'b0, in_valid3 = 1'b0, in_ready3, in_we3 = 1'b0, in_exc3 = 1'b0;
  logic [2:0]  in_id3 = '0, out_id3;
  logic [31:0] in_data3 = '0, out_data3;
  logic [4:0]  in_rd3 = '0, out_rd3;
  logic [5:0]  in_exccode3 = '0, out_exccode3;
  logic        out_valid3, out_ready3 = 1'b0, out_we3, out_exc3;
  logic [1:0]  count3;

  always #5 clk = ~clk;

  cvxif_result_queue #(.ID_W(3), .DATA_W(32), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_id_i(in_id), .in_data_i(in_data),
    .in_rd_i(in_rd), .in_we_i(in_we), .in_exc_i(in_exc), .in_exccode_i(in_exccode),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id), .out_data_o(out_data),
    .out_rd_o(out_rd), .out_we_o(out_we), .out_exc_o(out_exc), .out_exccode_o(out_exccode),
    .count_o(count)
  );

  cvxif_result_queue #(.ID_W(3), .DATA_W(32), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_id_i(in_id3), .in_data_i(in_data3),
    .in_rd_i(in_rd3), .in_we_i(in_we3), .in_exc_i(in_exc3), .in_exccode_i(in_exccode3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .out_id_o(out_id3), .out_data_o(out_data3),
    .out_rd_o(out_rd3), .out_we_o(out_we3), .out_exc_o(out_exc3), .out_exccode_o(out_exccode3),
    .count_o(count3)
  );

  task automatic drive4(input logic v, input int id, input logic [31:0] data);
    in_valid   = v;
    in_id      = 3'(id);
    in_data    = data;
    in_rd      = 5'(id);
    in_we      = 1'b1;
    in_exc     = 1'b0;
    in_exccode = 6'd0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'd0 || out_id !== 3'd0) begin n_err++; $display("FAIL reset_out_fields: got id=%0d data=%h want 0", out_id, out_data); end
    n_cmp++; if (count3 !== 2'd0 || in_ready3 !== 1'b1) begin n_err++; $display("FAIL reset_dut3: got count=%0d ready=%b want 0/1", count3, in_ready3); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_id = 3'd2; in_data = 32'hDEADBEEF; in_rd = 5'd5;
    in_we = 1'b1; in_exc = 1'b0; in_exccode = 6'd0; out_ready = 1'b1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_id !== 3'd2 || out_data !== 32'hDEADBEEF || out_rd !== 5'd5 || out_we !== 1'b1 || out_exc !== 1'b0)
      begin n_err++; $display("FAIL single_fields: got id=%0d data=%h rd=%0d we=%b exc=%b want 2/deadbeef/5/1/0", out_id, out_data, out_rd, out_we, out_exc); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got count=%0d valid=%b want 0/0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); end
      drive4(1'b1, i, 32'h1000 + 32'(i));
      @(negedge clk);
    end
    n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got count=%0d ready=%b want 4/0", count, in_ready); end
    drive4(1'b1, 7, 32'h7777);
    repeat (2) @(negedge clk);
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_held_off: got count=%0d want 4", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_id !== 3'd0 || out_data !== 32'h1000) begin n_err++; $display("FAIL fill_head0: got id=%0d data=%h want 0/1000", out_id, out_data); end
    @(negedge clk);
    n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_err++; $display("FAIL fill_after_pop: got count=%0d ready=%b want 3/1", count, in_ready); end
    n_cmp++; if (out_data !== 32'h1001) begin n_err++; $display("FAIL fill_head1: got %h want 1001", out_data); end
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (out_data !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL fill_head%0d: got %h want %h", i, out_data, 32'h1000 + 32'(i)); end
    end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_empty: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive4(1'b1, 0, 32'd0); @(negedge clk);
    drive4(1'b1, 1, 32'd1); @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      drive4(1'b1, k + 2, 32'(k + 2));
      out_ready = 1'b1;
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count_%0d: got %0d want 2", k, count); end
      n_cmp++; if (out_data !== 32'(k) || out_id !== 3'(k)) begin n_err++; $display("FAIL b2b_order_%0d: got data=%0d id=%0d want %0d", k, out_data, out_id, k); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'd20) begin n_err++; $display("FAIL b2b_tail20: got %0d want 20", out_data); end
    @(negedge clk);
    n_cmp++; if (out_data !== 32'd21) begin n_err++; $display("FAIL b2b_tail21: got %0d want 21", out_data); end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_empty: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    int  sent = 0;
    int  recv = 0;
    int  cyc  = 0;
    logic v, r;
    while (recv < 10 && cyc < 300) begin
      n_cmp++;
      if (count3 !== 2'(sent - recv) || out_valid3 !== (sent != recv)) begin
        n_err++; $display("FAIL wrap_count_c%0d: got count=%0d valid=%b want %0d", cyc, count3, out_valid3, sent - recv);
      end
      v = (sent < 10) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      in_valid3 = v; in_id3 = 3'(sent); in_data3 = 32'hA000 + 32'(sent);
      in_rd3 = 5'(sent); in_we3 = 1'b1; out_ready3 = r;
      if (r && out_valid3) begin
        n_cmp++;
        if (out_data3 !== 32'hA000 + 32'(recv) || out_id3 !== 3'(recv) || out_rd3 !== 5'(recv)) begin
          n_err++; $display("FAIL wrap_data_%0d: got %h want %h", recv, out_data3, 32'hA000 + 32'(recv));
        end
        recv++;
      end
      if (v && in_ready3) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid3 = 1'b0; out_ready3 = 1'b0;
    n_cmp++; if (recv != 10) begin n_err++; $display("FAIL wrap_timeout: got %0d delivered want 10", recv); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive4(1'b1, i, 32'h10 * 32'(i)); @(negedge clk);
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    flush = 1'b1; drive4(1'b1, 5, 32'h55);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_cycle_state: got valid=%b ready=%b want 1/1", out_valid, in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_cleared: got count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready); end
    n_cmp++; if (out_data !== 32'd0 || out_id !== 3'd0 || out_rd !== 5'd0 || out_we !== 1'b0) begin n_err++; $display("FAIL flush_fields: got id=%0d data=%h rd=%0d we=%b want 0", out_id, out_data, out_rd, out_we); end
    drive4(1'b1, 6, 32'h66); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h66 || count !== 3'd1) begin n_err++; $display("FAIL flush_next_entry: got valid=%b data=%h count=%0d want 1/66/1", out_valid, out_data, count); end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_drain: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive4(1'b1, 1, 32'hAA); @(negedge clk);
    drive4(1'b1, 2, 32'hBB); @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL arst_pre_count: got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_immediate: got valid=%b count=%0d ready=%b want 0/0/1", out_valid, count, in_ready); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL arst_fields: got %h want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cvxif_result_queue.md
Name: cvxif_result_queue

Overview:
- FIFO between the vector coprocessor result port and the CVA6 CV-X-IF result input.
- Decouples coprocessor result production from core writeback acceptance by buffering up to DEPTH result packets (id, data, rd, we, exc, exccode).
- Ready is registered-derived, so there is no combinational ready path from core to coprocessor.
- Supports a synchronous flush for pipeline kill or recovery.

Parameters:
ID_W, 3, width of the result transaction id (equals the core's TRANS_ID_BITS)
DATA_W, 32, result data width (equals riscv::XLEN)
DEPTH, 4, number of entries; legal range 2..16; need not be a power of two

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of all entries
in_valid_i  input  1  coprocessor result valid
in_ready_o  output  1  queue can accept a result
in_id_i  input  ID_W  result id
in_data_i  input  DATA_W  result data
in_rd_i  input  5  destination register
in_we_i  input  1  register write enable
in_exc_i  input  1  exception flag
in_exccode_i  input  6  exception code
out_valid_o  output  1  head entry valid toward core
out_ready_i  input  1  core accepts head entry
out_id_o  output  ID_W  head id
out_data_o  output  DATA_W  head data
out_rd_o  output  5  head rd
out_we_o  output  1  head we
out_exc_o  output  1  head exc
out_exccode_o  output  6  head exccode
count_o  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Clock and reset: single clock clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values: rd_ptr=0, wr_ptr=0, count=0. Hence out_valid_o=0, all out_* fields=0, count_o=0, in_ready_o=1. Storage contents need no reset.
- Handshakes:
  - push = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
  - in_ready_o = (count != DEPTH), derived from registered count only, never from out_ready_i.
  - out_valid_o = (count != 0).
- No fall-through. A push into an empty queue makes out_valid_o=1 on the following cycle, so minimum latency is 1 cycle input-to-output.
- Output fields come combinationally from storage[rd_ptr] when count != 0 and are forced to 0 when count == 0.
- Pointers are $clog2(DEPTH) bits wide. Each increments on its event and wraps from DEPTH-1 to 0; this must hold for non-power-of-two DEPTH (e.g. 3, 5).
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged, both pointers advance
  - neither: unchanged
- Full (count==DEPTH) with pop: the pop happens and in_ready_o is already 0, so no push that cycle. in_ready_o returns to 1 the next cycle.
- Empty with pop: cannot occur because out_valid_o=0.
- Flush:
  - When flush_i=1, pointers and count go to 0 at the next edge. It overrides any push or pop in the same cycle; a simultaneous push is dropped.
  - out_valid_o and in_ready_o still reflect the pre-flush state during the flush cycle. The environment must not rely on a handshake completing in that cycle.
- Reset mid-operation: asynchronous clear to reset values; queued results are lost.
- Ordering: strict FIFO. The id field is opaque and has no effect on ordering.
- Assertions (simulation only):
  - no push when count==DEPTH
  - out_* stable while out_valid_o & !out_ready_i
  - count_o <= DEPTH

Test Plan:
- Reset then single result: push id=2, data=0xDEADBEEF, rd=5, we=1 at cycle 0 with out_ready_i=1 -> out_valid_o=1 at cycle 1 with identical fields; count_o goes 0→1→0.
- Fill and backpressure, DEPTH=4, out_ready_i=0: push ids 0,1,2,3 -> in_ready_o=0 after the 4th push, count_o=4, a 5th in_valid_i is held off. Then one pop yields id=0, and in_ready_o=1 on the next cycle.
- Simultaneous push/pop at count=2 -> count_o stays 2; output order 0,1,2,… preserved over 20 continuous transfers at 1 per cycle.
- Wrap, DEPTH=3: push/pop 10 entries with random stalls -> every entry is delivered once, in order, with matching data, across pointer wrap 2→0.
- Flush with count=3 plus in_valid_i=1 in the same cycle -> next cycle count_o=0, out_valid_o=0, out_* =0, and the pushed entry never appears.
- Async reset asserted while count=2 and stalled -> out_valid_o=0 and count_o=0 immediately, without a clock edge; in_ready_o=1.
